irig_encoder: RTL

- Generates an IRIG-B (B00x, DC level-shift) timecode stream from a binary timestamp: day of year, two-digit year and second of day.
- Counterpart to the IRIG width decoder/timestamp pipeline. It drives test benches, loopback self-test and slave timing outputs.
- Converts binary fields to BCD with a small sequential converter once per frame. Emits a PPS strobe aligned to each frame's on-time edge.

---
 rtl/irig_encoder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/irig_encoder.sv
// IRIG-B (B00x, DC level-shift) generator: samples a binary timestamp once per
// frame at bit 99, converts it to BCD with a compare/subtract engine, and emits the frame.
//
// state | meaning
// IDLE  | waiting for the bit-99 timestamp sample
// HRS   | peel hours off the second-of-day remainder (subtract 3600)
// MIN   | peel minutes off the remainder (subtract 60)
// DIG   | split s/m/h/day/year into BCD tens and hundreds
// DONE  | load BCD fields and SBS into the frame holding registers
module irig_encoder #(
  parameter int CLKS_PER_BIT = 100000,
  parameter int ZERO_HIGH    = 20000,
  parameter int ONE_HIGH     = 50000,
  parameter int MARK_HIGH    = 80000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [8:0]  ts_day,
  input  logic [6:0]  ts_year,
  input  logic [16:0] ts_sec_day,
  output logic        ts_ack,
  output logic        ts_err,
  output logic        irigb,
  output logic        pps
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] W_ZERO   = CNT_W'(ZERO_HIGH);
  localparam logic [CNT_W-1:0] W_ONE    = CNT_W'(ONE_HIGH);
  localparam logic [CNT_W-1:0] W_MARK   = CNT_W'(MARK_HIGH);

  typedef enum logic [2:0] {IDLE, HRS, MIN, DIG, DONE} conv_state_t;

  conv_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       bit_idx;
  logic             bad;
  logic [16:0]      rem, sbs_smp;
  logic [5:0]       hrs, mins;
  logic [2:0]       s_t, m_t;
  logic [1:0]       h_t, d_h;
  logic [8:0]       d_rem;
  logic [3:0]       d_t, y_t;
  logic [6:0]       y_rem;

  logic [3:0]       sec_u, min_u, hr_u, day_u, day_t, yr_u, yr_t;
  logic [2:0]       sec_t, min_t;
  logic [1:0]       hr_t, day_h;
  logic [16:0]      sbs;

  logic             sample, ts_bad, is_marker, dig_busy;
  logic [99:0]      data;
  logic [CNT_W-1:0] cur_w;

  // The acknowledge is combinational so it coincides with the cycle whose
  // closing edge captures ts_*, including the very first enabled cycle.
  assign sample = enable && (cnt == '0) && (bit_idx == 7'd99);
  assign ts_bad = (ts_sec_day > 17'd86399) || (ts_day == 9'd0) ||
                  (ts_day > 9'd366) || (ts_year > 7'd99);
  assign ts_ack = sample && !rst;
  assign ts_err = ts_ack && ts_bad;

  assign dig_busy = (rem >= 17'd10) || (mins >= 6'd10) || (hrs >= 6'd10) ||
                    (d_rem >= 9'd10) || (y_rem >= 7'd10);

  always_comb begin
    is_marker = (bit_idx == 7'd0);
    for (int i = 0; i < 10; i++)
      if (bit_idx == 7'(10 * i + 9)) is_marker = 1'b1;
  end

  always_comb begin
    data        = '0;
    data[4:1]   = sec_u;
    data[8:6]   = sec_t;
    data[13:10] = min_u;
    data[17:15] = min_t;
    data[23:20] = hr_u;
    data[26:25] = hr_t;
    data[33:30] = day_u;
    data[38:35] = day_t;
    data[41:40] = day_h;
    data[53:50] = yr_u;
    data[58:55] = yr_t;
    data[88:80] = sbs[8:0];
    data[97:90] = sbs[16:9];
  end

  always_comb begin
    cur_w = W_ZERO;
    if (is_marker)          cur_w = W_MARK;
    else if (data[bit_idx]) cur_w = W_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt     <= '0;
      bit_idx <= 7'd99;
      irigb   <= 1'b0;
      pps     <= 1'b0;
      state   <= IDLE;
      bad     <= 1'b0;
      rem     <= '0;
      sbs_smp <= '0;
      hrs     <= '0;
      mins    <= '0;
      s_t     <= '0;
      m_t     <= '0;
      h_t     <= '0;
      d_rem   <= '0;
      d_h     <= '0;
      d_t     <= '0;
      y_rem   <= '0;
      y_t     <= '0;
      sec_u   <= '0;
      sec_t   <= '0;
      min_u   <= '0;
      min_t   <= '0;
      hr_u    <= '0;
      hr_t    <= '0;
      day_u   <= '0;
      day_t   <= '0;
      day_h   <= '0;
      yr_u    <= '0;
      yr_t    <= '0;
      sbs     <= '0;
    end else begin
      irigb <= (cnt < cur_w);
      pps   <= (cnt == '0) && (bit_idx == 7'd0);
      if (cnt == CNT_LAST) begin
        cnt     <= '0;
        bit_idx <= (bit_idx == 7'd99) ? 7'd0 : bit_idx + 7'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (sample) begin
        state   <= HRS;
        bad     <= ts_bad;
        rem     <= ts_sec_day;
        sbs_smp <= ts_sec_day;
        d_rem   <= ts_day;
        y_rem   <= ts_year;
        hrs     <= '0;
        mins    <= '0;
        s_t     <= '0;
        m_t     <= '0;
        h_t     <= '0;
        d_h     <= '0;
        d_t     <= '0;
        y_t     <= '0;
      end else begin
        case (state)
          HRS: begin
            if (rem >= 17'd3600) begin
              rem <= rem - 17'd3600;
              hrs <= hrs + 6'd1;
            end else state <= MIN;
          end
          MIN: begin
            if (rem >= 17'd60) begin
              rem  <= rem - 17'd60;
              mins <= mins + 6'd1;
            end else state <= DIG;
          end
          DIG: begin
            if (rem >= 17'd10) begin
              rem <= rem - 17'd10;
              s_t <= s_t + 3'd1;
            end
            if (mins >= 6'd10) begin
              mins <= mins - 6'd10;
              m_t  <= m_t + 3'd1;
            end
            if (hrs >= 6'd10) begin
              hrs <= hrs - 6'd10;
              h_t <= h_t + 2'd1;
            end
            if (d_rem >= 9'd100) begin
              d_rem <= d_rem - 9'd100;
              d_h   <= d_h + 2'd1;
            end else if (d_rem >= 9'd10) begin
              d_rem <= d_rem - 9'd10;
              d_t   <= d_t + 4'd1;
            end
            if (y_rem >= 7'd10) begin
              y_rem <= y_rem - 7'd10;
              y_t   <= y_t + 4'd1;
            end
            if (!dig_busy) state <= DONE;
          end
          DONE: begin
            // An out-of-range sample yields a frame of all-zero data bits.
            sec_u <= bad ? 4'd0 : rem[3:0];
            sec_t <= bad ? 3'd0 : s_t;
            min_u <= bad ? 4'd0 : mins[3:0];
            min_t <= bad ? 3'd0 : m_t;
            hr_u  <= bad ? 4'd0 : hrs[3:0];
            hr_t  <= bad ? 2'd0 : h_t;
            day_u <= bad ? 4'd0 : d_rem[3:0];
            day_t <= bad ? 4'd0 : d_t;
            day_h <= bad ? 2'd0 : d_h;
            yr_u  <= bad ? 4'd0 : y_rem[3:0];
            yr_t  <= bad ? 4'd0 : y_t;
            sbs   <= bad ? 17'd0 : sbs_smp;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
